sssp_vertex_buffer: RTL and testbench

- Vertex-attribute store that answers the SSSP processing pipeline's buffer interface.
- Serves source/destination attribute reads with a fixed 2-cycle latency.
- Absorbs gather write-backs {active bit, distance}, with read-after-write bypass so in-flight writes are never missed.
- Provides two sweep operations: partition init (all vertices INF, one source vertex at distance 0) and a between-iterations active-bit clear that also counts active vertices.

---
 rtl/sssp_vertex_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_sssp_vertex_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sssp_vertex_buffer.sv
// Vertex attribute store for the SSSP pipeline: 2-cycle reads with write bypass,
// gather write-backs, and init / active-clear sweeps over the whole partition.
module sssp_vertex_buffer #(
    parameter int                      PAR_SIZE_W  = 18,
    parameter int                      PAR_DEPTH   = 262144,
    parameter int                      URAM_DATA_W = 32,
    parameter logic [URAM_DATA_W-2:0]  INF_VAL     = 31'h7FFFFFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PAR_SIZE_W-1:0]   rd_addr,
    input  logic                    rd_valid,
    output logic [URAM_DATA_W-1:0]  buffer_Din,
    output logic                    buffer_Din_valid,
    input  logic [URAM_DATA_W-1:0]  buffer_Dout,
    input  logic [PAR_SIZE_W-1:0]   buffer_Dout_Addr,
    input  logic                    buffer_Dout_valid,
    input  logic                    init_start,
    input  logic [PAR_SIZE_W-1:0]   init_src,
    input  logic                    clear_start,
    output logic                    busy,
    output logic                    done,
    output logic [PAR_SIZE_W:0]     active_count,
    output logic                    err
);

    localparam int IDX_W = (PAR_DEPTH > 1) ? $clog2(PAR_DEPTH) : 1;
    localparam int CNT_W = PAR_SIZE_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(PAR_DEPTH);
    localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(PAR_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_CLR  = CNT_W'(PAR_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_CLEAR
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        idx_q;
    logic [PAR_SIZE_W-1:0]   src_q;
    logic                    busy_q;
    logic                    done_q;

    // Sweep controller; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (init_start) begin
                        state_q <= S_INIT;
                        idx_q   <= '0;
                        src_q   <= init_src;
                        busy_q  <= 1'b1;
                    end else if (clear_start) begin
                        state_q <= S_CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_INIT: begin
                    if (idx_q == LAST_INIT) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (idx_q == LAST_CLR) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [URAM_DATA_W-1:0]  mem_q [PAR_DEPTH];
    logic [URAM_DATA_W-1:0]  mem_rd_q;

    logic                    s1_valid_q, s1_valid_d;
    logic [PAR_SIZE_W-1:0]   s1_addr_q, s1_addr_d;
    logic                    s1_oor_q, s1_oor_d;
    logic                    s1_byp_q, s1_byp_d;
    logic [URAM_DATA_W-1:0]  s1_bdata_q, s1_bdata_d;
    logic                    dout_valid_q, dout_valid_d;
    logic [URAM_DATA_W-1:0]  dout_data_q, dout_data_d;
    logic                    clr_v1_q, clr_v1_d;
    logic [IDX_W-1:0]        clr_a1_q, clr_a1_d;
    logic                    clr_v2_q, clr_v2_d;
    logic [IDX_W-1:0]        clr_a2_q, clr_a2_d;
    logic [URAM_DATA_W-1:0]  clr_data_q, clr_data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic                    idle;
    logic                    rd_acc;
    logic                    wr_acc;
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_wa;
    logic [URAM_DATA_W-1:0]  mem_wd;
    logic [IDX_W-1:0]        mem_ra;
    logic [URAM_DATA_W-1:0]  rd_merged;

    always_comb begin
        idle   = (state_q == S_IDLE);
        rd_acc = rd_valid && idle;
        wr_acc = buffer_Dout_valid && idle
                 && ({1'b0, buffer_Dout_Addr} < DEPTH_C);

        // Sweep traffic owns the memory ports whenever a sweep is running.
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (state_q == S_INIT) begin
            mem_we = 1'b1;
            mem_wa = idx_q[IDX_W-1:0];
            if (idx_q == {1'b0, src_q}) begin
                mem_wd = {1'b1, {(URAM_DATA_W-1){1'b0}}};
            end else begin
                mem_wd = {1'b0, INF_VAL};
            end
        end else if (clr_v2_q) begin
            mem_we = 1'b1;
            mem_wa = clr_a2_q;
            mem_wd = {1'b0, clr_data_q[URAM_DATA_W-2:0]};
        end else if (wr_acc) begin
            mem_we = 1'b1;
            mem_wa = buffer_Dout_Addr[IDX_W-1:0];
            mem_wd = buffer_Dout;
        end
        if (rst) begin
            mem_we = 1'b0;
        end
        mem_ra = (state_q == S_CLEAR) ? idx_q[IDX_W-1:0]
                                      : rd_addr[IDX_W-1:0];

        s1_valid_d = rd_acc;
        s1_addr_d  = rd_addr;
        s1_oor_d   = !({1'b0, rd_addr} < DEPTH_C);
        s1_byp_d   = wr_acc && (buffer_Dout_Addr == rd_addr);
        s1_bdata_d = buffer_Dout;

        // Youngest write wins: the write one cycle after the read overrides.
        rd_merged = s1_byp_q ? s1_bdata_q : mem_rd_q;
        if (wr_acc && (buffer_Dout_Addr == s1_addr_q)) begin
            rd_merged = buffer_Dout;
        end
        if (s1_oor_q) begin
            rd_merged = '0;
        end
        dout_valid_d = s1_valid_q;
        dout_data_d  = s1_valid_q ? rd_merged : dout_data_q;

        clr_v1_d   = (state_q == S_CLEAR) && (idx_q < DEPTH_C);
        clr_a1_d   = idx_q[IDX_W-1:0];
        clr_v2_d   = clr_v1_q;
        clr_a2_d   = clr_a1_q;
        clr_data_d = mem_rd_q;

        cnt_d = cnt_q;
        if (idle && !init_start && clear_start) begin
            cnt_d = '0;
        end else if (clr_v2_q && clr_data_q[URAM_DATA_W-1]) begin
            cnt_d = cnt_q + 1'b1;
        end

        err_d = err_q || ((rd_valid || buffer_Dout_valid) && !idle);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
        mem_rd_q <= mem_q[mem_ra];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_oor_q     <= 1'b0;
            s1_byp_q     <= 1'b0;
            s1_bdata_q   <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            clr_v1_q     <= 1'b0;
            clr_a1_q     <= '0;
            clr_v2_q     <= 1'b0;
            clr_a2_q     <= '0;
            clr_data_q   <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_oor_q     <= s1_oor_d;
            s1_byp_q     <= s1_byp_d;
            s1_bdata_q   <= s1_bdata_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            clr_v1_q     <= clr_v1_d;
            clr_a1_q     <= clr_a1_d;
            clr_v2_q     <= clr_v2_d;
            clr_a2_q     <= clr_a2_d;
            clr_data_q   <= clr_data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign buffer_Din       = dout_data_q;
    assign buffer_Din_valid = dout_valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign active_count     = cnt_q;
    assign err              = err_q;

endmodule

// File: tb/tb_sssp_vertex_buffer.sv
// Directed bench for sssp_vertex_buffer with a 16-entry partition.
module tb_sssp_vertex_buffer;

    localparam int AW = 5;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [31:0]   din;
    logic          vld;
    logic [31:0]   wd;
    logic [AW-1:0] wa;
    logic          we;
    logic          init_start;
    logic [AW-1:0] init_src;
    logic          clear_start;
    logic          busy;
    logic          done;
    logic [AW:0]   active_count;
    logic          err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] mdl [D];

    typedef struct {
        logic          rd;
        logic [AW-1:0] ra;
        logic          we;
        logic [AW-1:0] wa;
        logic [31:0]   wd;
        logic          ev;
        logic [31:0]   ed;
    } vec_t;

    vec_t vt [20];

    always #5 clk = ~clk;

    sssp_vertex_buffer #(
        .PAR_SIZE_W (AW),
        .PAR_DEPTH  (D)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rd_addr           (rd_addr),
        .rd_valid          (rd_valid),
        .buffer_Din        (din),
        .buffer_Din_valid  (vld),
        .buffer_Dout       (wd),
        .buffer_Dout_Addr  (wa),
        .buffer_Dout_valid (we),
        .init_start        (init_start),
        .init_src          (init_src),
        .clear_start       (clear_start),
        .busy              (busy),
        .done              (done),
        .active_count      (active_count),
        .err               (err)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [AW-1:0] ra,
                                input logic w, input logic [AW-1:0] a,
                                input logic [31:0] d, input logic ev,
                                input logic [31:0] ed);
        vec_t v;
        v.rd = r; v.ra = ra; v.we = w; v.wa = a;
        v.wd = d; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    function automatic void init_model(input int src);
        for (int i = 0; i < D; i++)
            mdl[i] = (i == src) ? 32'h80000000 : 32'h7FFFFFFF;
    endfunction

    task automatic wr(input int a, input logic [31:0] d);
        we = 1'b1; wa = AW'(a); wd = d;
        tick;
        we = 1'b0;
        if (a < D) mdl[a] = d;
    endtask

    task automatic read_all(input string nm);
        for (int i = 0; i < D + 2; i++) begin
            if (i >= 2) begin
                chk({nm, " vld"}, {31'd0, vld}, 32'd1);
                chk({nm, " data"}, din, mdl[i-2]);
            end else begin
                chk({nm, " idle vld"}, {31'd0, vld}, 32'd0);
            end
            rd_valid = (i < D);
            rd_addr  = AW'(i);
            tick;
        end
        rd_valid = 1'b0;
    endtask

    // Entered in the cycle right after the start pulse.
    task automatic wait_done(input string nm, input int exp_n);
        int n = 0;
        chk({nm, " busy rise"}, {31'd0, busy}, 32'd1);
        while (!done && n < 200) begin
            tick;
            n++;
        end
        chk({nm, " cycles"}, n, exp_n);
        chk({nm, " busy at done"}, {31'd0, busy}, 32'd0);
        tick;
        chk({nm, " done pulse"}, {31'd0, done}, 32'd0);
        chk({nm, " stays idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;

        vt[0]  = mk(1, 3,  0, 0,  32'h0,        0, 32'h0);
        vt[1]  = mk(1, 3,  0, 0,  32'h0,        0, 32'h0);
        vt[2]  = mk(1, 3,  1, 3,  32'h8000000A, 1, 32'h7FFFFFFF);
        vt[3]  = mk(1, 3,  0, 0,  32'h0,        1, 32'h8000000A);
        vt[4]  = mk(1, 7,  1, 7,  32'h80000009, 1, 32'h8000000A);
        vt[5]  = mk(0, 0,  1, 7,  32'h80000004, 1, 32'h8000000A);
        vt[6]  = mk(1, 5,  0, 0,  32'h0,        1, 32'h80000004);
        vt[7]  = mk(1, 16, 1, 20, 32'h0000DEAD, 0, 32'h0);
        vt[8]  = mk(1, 20, 0, 0,  32'h0,        1, 32'h80000000);
        vt[9]  = mk(0, 0,  0, 0,  32'h0,        1, 32'h0);
        vt[10] = mk(0, 0,  0, 0,  32'h0,        1, 32'h0);
        vt[11] = mk(0, 0,  1, 2,  32'h80000010, 0, 32'h0);
        vt[12] = mk(1, 2,  0, 0,  32'h0,        0, 32'h0);
        vt[13] = mk(0, 0,  0, 0,  32'h0,        0, 32'h0);
        vt[14] = mk(0, 0,  0, 0,  32'h0,        1, 32'h80000010);
        vt[15] = mk(1, 9,  1, 9,  32'h80000020, 0, 32'h0);
        vt[16] = mk(0, 0,  1, 8,  32'h00000055, 0, 32'h0);
        vt[17] = mk(0, 0,  1, 15, 32'h80000030, 1, 32'h80000020);
        vt[18] = mk(0, 0,  0, 0,  32'h0,        0, 32'h0);
        vt[19] = mk(0, 0,  0, 0,  32'h0,        0, 32'h0);

        rst = 1'b1; rd_addr = '0; rd_valid = 1'b0;
        wd = '0; wa = '0; we = 1'b0;
        init_start = 1'b0; init_src = '0; clear_start = 1'b0;
        tick;
        tick;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst vld", {31'd0, vld}, 32'd0);
        chk("rst din", din, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst cnt", {26'd0, active_count}, 32'd0);
        rst = 1'b0;
        tick;

        // Both starts together: init must win (16 cycles, not 18).
        init_src = 5; init_start = 1'b1; clear_start = 1'b1;
        tick;
        init_start = 1'b0; clear_start = 1'b0; init_src = 9;
        wait_done("init", 16);
        init_model(5);
        read_all("init_rb");

        for (int k = 0; k < 20; k++) begin
            chk($sformatf("vec%0d vld", k), {31'd0, vld}, {31'd0, vt[k].ev});
            if (vt[k].ev)
                chk($sformatf("vec%0d data", k), din, vt[k].ed);
            rd_valid = vt[k].rd; rd_addr = vt[k].ra;
            we = vt[k].we; wa = vt[k].wa; wd = vt[k].wd;
            if (vt[k].we && vt[k].wa < D) mdl[vt[k].wa] = vt[k].wd;
            tick;
        end
        rd_valid = 1'b0; we = 1'b0;
        chk("oor no err", {31'd0, err}, 32'd0);
        read_all("byp_rb");

        init_src = 5; init_start = 1'b1;
        tick;
        init_start = 1'b0;
        wait_done("init2", 16);
        init_model(5);
        wr(2, 32'h80000011);
        wr(9, 32'h80000022);
        wr(15, 32'h8000000F);
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        wait_done("clear", 18);
        chk("clear count", {26'd0, active_count}, 32'd4);
        for (int i = 0; i < D; i++) mdl[i][31] = 1'b0;
        read_all("clr_rb");
        chk("clear no err", {31'd0, err}, 32'd0);

        // Requests and a start pulse injected at sweep index 4.
        init_src = 5; init_start = 1'b1;
        tick;
        init_start = 1'b0;
        chk("err busy rise", {31'd0, busy}, 32'd1);
        repeat (4) tick;
        rd_valid = 1'b1; rd_addr = 0;
        we = 1'b1; wa = 1; wd = 32'h12345678;
        clear_start = 1'b1;
        tick;
        rd_valid = 1'b0; we = 1'b0; clear_start = 1'b0;
        n = 5;
        while (!done && n < 200) begin
            chk("sweep vld", {31'd0, vld}, 32'd0);
            tick;
            n++;
        end
        chk("err cycles", n, 16);
        chk("err flag", {31'd0, err}, 32'd1);
        tick;
        chk("err no clear", {31'd0, busy}, 32'd0);
        init_model(5);
        read_all("err_rb");
        chk("err sticky", {31'd0, err}, 32'd1);

        for (int i = 0; i < D; i++) wr(i, 32'h100 + i);
        init_start = 1'b1;
        tick;
        init_start = 1'b0;
        repeat (8) tick;
        rst = 1'b1;
        tick;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick;
        chk("abort done2", {31'd0, done}, 32'd0);
        for (int i = 0; i < 8; i++)
            mdl[i] = (i == 5) ? 32'h80000000 : 32'h7FFFFFFF;
        read_all("abort_rb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
